// File: rtl/vtc_pkg.sv
// Shared timing sets, polarity constants and helpers for the video
// timing generator.
package vtc_pkg;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    typedef struct packed {
        int h_area;
        int h_fporch;
        int h_sync;
        int h_bporch;
        int v_area;
        int v_fporch;
        int v_sync;
        int v_bporch;
        bit h_pol;
        bit v_pol;
    } vtc_timing_t;

    localparam vtc_timing_t VGA640x480 = '{
        h_area:   640,
        h_fporch: 16,
        h_sync:   96,
        h_bporch: 48,
        v_area:   480,
        v_fporch: 10,
        v_sync:   2,
        v_bporch: 33,
        h_pol:    POL_LOW,
        v_pol:    POL_LOW
    };

    localparam vtc_timing_t SVGA800x600 = '{
        h_area:   800,
        h_fporch: 40,
        h_sync:   128,
        h_bporch: 88,
        v_area:   600,
        v_fporch: 1,
        v_sync:   4,
        v_bporch: 23,
        h_pol:    POL_HIGH,
        v_pol:    POL_HIGH
    };

    function automatic int calc_total(
        input int area,
        input int fp,
        input int sync,
        input int bp
    );
        return area + fp + sync + bp;
    endfunction

    function automatic logic in_window(
        input int x,
        input int lo,
        input int hi
    );
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vtc_gen_axis_counter.sv
// Wrapping position counter for one timing axis, with area/sync
// window flags evaluated on the value the counter is about to take.
module axis_counter
    import vtc_pkg::*;
#(
    parameter int MAX     = 799,
    parameter int W       = 12,
    parameter int AREA    = 640,
    parameter int SYNC_LO = 656,
    parameter int SYNC_HI = 752
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         in_area,
    output logic         in_sync
);

    localparam logic [W-1:0] LAST = W'(MAX);

    logic [W-1:0] next_count;

    always_comb begin
        next_count = count;
        if (en) begin
            next_count = (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign wrap = en && (count == LAST);

    // Flags look ahead so the registered outputs line up with count.
    assign in_area = in_window(int'(next_count), 0, AREA);
    assign in_sync = in_window(int'(next_count), SYNC_LO, SYNC_HI);

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= LAST;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/vtc_gen.sv
// Parametrised video timing generator: counters, syncs, active flags,
// line/frame strobes and a completed-frame counter.
module vtc_gen
    import vtc_pkg::*;
#(
    parameter int H_AREA   = VGA640x480.h_area,
    parameter int H_FPORCH = VGA640x480.h_fporch,
    parameter int H_SYNC   = VGA640x480.h_sync,
    parameter int H_BPORCH = VGA640x480.h_bporch,
    parameter int V_AREA   = VGA640x480.v_area,
    parameter int V_FPORCH = VGA640x480.v_fporch,
    parameter int V_SYNC   = VGA640x480.v_sync,
    parameter int V_BPORCH = VGA640x480.v_bporch,
    parameter bit H_POL    = VGA640x480.h_pol,
    parameter bit V_POL    = VGA640x480.v_pol,
    parameter int CW       = 12,
    parameter int FCW      = 16
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           en,
    output logic           hSync,
    output logic           vSync,
    output logic           hActive,
    output logic           vActive,
    output logic [CW-1:0]  hPixel,
    output logic [CW-1:0]  vLine,
    output logic           lineStart,
    output logic           frameStart,
    output logic [FCW-1:0] frameCount
);

    localparam int HTOT = calc_total(H_AREA, H_FPORCH, H_SYNC, H_BPORCH);
    localparam int VTOT = calc_total(V_AREA, V_FPORCH, V_SYNC, V_BPORCH);

    if (H_AREA == 0 || H_FPORCH == 0 || H_SYNC == 0 || H_BPORCH == 0 ||
        V_AREA == 0 || V_FPORCH == 0 || V_SYNC == 0 || V_BPORCH == 0 ||
        CW == 0 || FCW == 0) begin : g_err_zero
        $error("vtc_gen: timing and width parameters must be non-zero");
    end

    if (HTOT > 2**CW || VTOT > 2**CW) begin : g_err_width
        $error("vtc_gen: HTOT/VTOT do not fit in CW bits");
    end

    logic h_wrap;
    logic h_area;
    logic h_sync;
    logic v_en;
    logic v_wrap;
    logic v_area;
    logic v_sync;
    logic first_done;

    axis_counter #(
        .MAX     (HTOT - 1),
        .W       (CW),
        .AREA    (H_AREA),
        .SYNC_LO (H_AREA + H_FPORCH),
        .SYNC_HI (H_AREA + H_FPORCH + H_SYNC)
    ) u_h (
        .clock   (clock),
        .rst     (rst),
        .en      (en),
        .count   (hPixel),
        .wrap    (h_wrap),
        .in_area (h_area),
        .in_sync (h_sync)
    );

    assign v_en = en && h_wrap;

    axis_counter #(
        .MAX     (VTOT - 1),
        .W       (CW),
        .AREA    (V_AREA),
        .SYNC_LO (V_AREA + V_FPORCH),
        .SYNC_HI (V_AREA + V_FPORCH + V_SYNC)
    ) u_v (
        .clock   (clock),
        .rst     (rst),
        .en      (v_en),
        .count   (vLine),
        .wrap    (v_wrap),
        .in_area (v_area),
        .in_sync (v_sync)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            hActive    <= 1'b0;
            vActive    <= 1'b0;
            hSync      <= ~H_POL;
            vSync      <= ~V_POL;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            frameCount <= '0;
            first_done <= 1'b0;
        end else begin
            lineStart  <= h_wrap;
            frameStart <= v_wrap;
            if (en) begin
                hActive <= h_area;
                vActive <= h_area && v_area;
                hSync   <= h_sync ? H_POL : ~H_POL;
                vSync   <= v_sync ? V_POL : ~V_POL;
            end
            // The frame entered straight out of reset is not a completed one.
            if (v_wrap) begin
                if (first_done) begin
                    frameCount <= frameCount + FCW'(1);
                end
                first_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vtc_gen.sv
// Directed bench: default VGA instance for line timing, a small
// active-high instance for frame, enable and mid-frame reset behaviour.
module tb_vtc_gen;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic        en_s  = 1'b0;

    logic        hSync, vSync, hActive, vActive, lineStart, frameStart;
    logic [11:0] hPixel, vLine;
    logic [15:0] frameCount;

    logic        s_hSync, s_vSync, s_hActive, s_vActive;
    logic        s_lineStart, s_frameStart;
    logic [3:0]  s_hPixel, s_vLine, s_frameCount;

    int n_tests = 0;
    int n_fail  = 0;

    int mh, mv, mls, mfs, mfc, seen;
    int cyc     = 0;
    int last_fs = -1;
    int hs_low  = 0;
    int n       = 0;

    always #5 clock = ~clock;

    vtc_gen dut (
        .clock      (clock),
        .rst        (rst),
        .en         (en),
        .hSync      (hSync),
        .vSync      (vSync),
        .hActive    (hActive),
        .vActive    (vActive),
        .hPixel     (hPixel),
        .vLine      (vLine),
        .lineStart  (lineStart),
        .frameStart (frameStart),
        .frameCount (frameCount)
    );

    vtc_gen #(
        .H_AREA (8), .H_FPORCH (2), .H_SYNC (3), .H_BPORCH (2),
        .V_AREA (4), .V_FPORCH (1), .V_SYNC (2), .V_BPORCH (1),
        .H_POL  (1'b1), .V_POL (1'b1), .CW (4), .FCW (4)
    ) dut_s (
        .clock      (clock),
        .rst        (rst),
        .en         (en_s),
        .hSync      (s_hSync),
        .vSync      (s_vSync),
        .hActive    (s_hActive),
        .vActive    (s_vActive),
        .hPixel     (s_hPixel),
        .vLine      (s_vLine),
        .lineStart  (s_lineStart),
        .frameStart (s_frameStart),
        .frameCount (s_frameCount)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Small instance: HTOT 15, VTOT 8, FCW 4.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (rst) begin
            mh = 14; mv = 7; mls = 0; mfs = 0; mfc = 0; seen = 0;
        end else if (en_s) begin
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 7) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mls = (mh == 0) ? 1 : 0;
            mfs = (mh == 0 && mv == 0) ? 1 : 0;
            if (mfs == 1) begin
                if (seen == 1) mfc = (mfc + 1) % 16;
                seen = 1;
            end
        end else begin
            mls = 0;
            mfs = 0;
        end
    endtask

    task automatic check_s(input string p);
        chk({p, ".hp"}, int'(s_hPixel), mh);
        chk({p, ".vl"}, int'(s_vLine), mv);
        chk({p, ".hs"}, int'(s_hSync), (mh >= 10 && mh < 13) ? 1 : 0);
        chk({p, ".vs"}, int'(s_vSync), (mv >= 5 && mv < 7) ? 1 : 0);
        chk({p, ".ha"}, int'(s_hActive), (mh < 8) ? 1 : 0);
        chk({p, ".va"}, int'(s_vActive), (mh < 8 && mv < 4) ? 1 : 0);
        chk({p, ".ls"}, int'(s_lineStart), mls);
        chk({p, ".fs"}, int'(s_frameStart), mfs);
        chk({p, ".fc"}, int'(s_frameCount), mfc);
    endtask

    task automatic fs_track(input int period);
        if (s_frameStart) begin
            if (last_fs >= 0) chk("fs_period", cyc - last_fs, period);
            last_fs = cyc;
        end
    endtask

    initial begin
        step();
        step();
        chk("rst.hp", int'(hPixel), 799);
        chk("rst.vl", int'(vLine), 524);
        chk("rst.ha", int'(hActive), 0);
        chk("rst.va", int'(vActive), 0);
        chk("rst.hs", int'(hSync), 1);
        chk("rst.vs", int'(vSync), 1);
        chk("rst.ls", int'(lineStart), 0);
        chk("rst.fs", int'(frameStart), 0);
        chk("rst.fc", int'(frameCount), 0);
        check_s("s_rst");
        chk("s_rst.hs_lvl", int'(s_hSync), 0);

        rst  = 1'b0;
        en   = 1'b1;
        en_s = 1'b1;
        step();
        chk("first.hp", int'(hPixel), 0);
        chk("first.vl", int'(vLine), 0);
        chk("first.ha", int'(hActive), 1);
        chk("first.va", int'(vActive), 1);
        chk("first.ls", int'(lineStart), 1);
        chk("first.fs", int'(frameStart), 1);
        chk("first.hs", int'(hSync), 1);
        chk("first.vs", int'(vSync), 1);
        chk("first.fc", int'(frameCount), 0);
        check_s("s_first");

        en_s = 1'b0;
        for (int i = 1; i < 800; i++) begin
            step();
            chk("line.hp", int'(hPixel), i);
            chk("line.hs", int'(hSync), (i >= 656 && i < 752) ? 0 : 1);
            chk("line.ha", int'(hActive), (i < 640) ? 1 : 0);
            chk("line.va", int'(vActive), (i < 640) ? 1 : 0);
            chk("line.ls", int'(lineStart), 0);
            if (!hSync) hs_low++;
        end
        chk("line.hs_low_cnt", hs_low, 96);
        step();
        chk("line2.hp", int'(hPixel), 0);
        chk("line2.vl", int'(vLine), 1);
        chk("line2.ls", int'(lineStart), 1);
        chk("line2.fs", int'(frameStart), 0);
        chk("line2.ha", int'(hActive), 1);
        chk("line2.vs", int'(vSync), 1);
        check_s("s_hold");

        en   = 1'b0;
        en_s = 1'b1;
        last_fs = -1;
        repeat (240) begin
            step();
            check_s("s_run");
            fs_track(120);
        end

        last_fs = -1;
        for (int i = 0; i < 720; i++) begin
            en_s = (i % 2 == 0);
            step();
            check_s("s_tog");
            fs_track(240);
        end
        chk("s_tog.fc_end", int'(s_frameCount), 5);

        en_s = 1'b1;
        n = 0;
        while (!(mh == 5 && mv == 3) && n < 200) begin
            step();
            check_s("s_seek");
            n++;
        end
        chk("s_seek.in_budget", (n < 200) ? 1 : 0, 1);
        chk("s_seek.fc", int'(s_frameCount), 5);

        rst = 1'b1;
        step();
        check_s("s_midrst");
        chk("s_midrst.hp", int'(s_hPixel), 14);
        chk("s_midrst.vl", int'(s_vLine), 7);
        chk("s_midrst.va", int'(s_vActive), 0);
        chk("s_midrst.fc", int'(s_frameCount), 0);
        chk("midrst.hp", int'(hPixel), 799);
        chk("midrst.vl", int'(vLine), 524);

        rst = 1'b0;
        step();
        check_s("s_post");
        chk("s_post.hp", int'(s_hPixel), 0);
        chk("s_post.fs", int'(s_frameStart), 1);
        chk("s_post.fc", int'(s_frameCount), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
